// File: rtl/ps2_letter_decoder_pkg.sv
// Shared definitions for the PS/2 letter decoder: widths, prefix bytes,
// frame FSM states and the A-Z scan-code to one-hot mapping.
package ps2_letter_decoder_pkg;

    localparam int         LETTER_W  = 26;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    // Bit 0 = A ... bit 25 = Z; any other code maps to all zeros.
    function automatic logic [LETTER_W-1:0] scan_to_onehot(input logic [7:0] code);
        logic [LETTER_W-1:0] oh;
        oh = '0;
        case (code)
            8'h1C: oh[0]  = 1'b1;
            8'h32: oh[1]  = 1'b1;
            8'h21: oh[2]  = 1'b1;
            8'h23: oh[3]  = 1'b1;
            8'h24: oh[4]  = 1'b1;
            8'h2B: oh[5]  = 1'b1;
            8'h34: oh[6]  = 1'b1;
            8'h33: oh[7]  = 1'b1;
            8'h43: oh[8]  = 1'b1;
            8'h3B: oh[9]  = 1'b1;
            8'h42: oh[10] = 1'b1;
            8'h4B: oh[11] = 1'b1;
            8'h3A: oh[12] = 1'b1;
            8'h31: oh[13] = 1'b1;
            8'h44: oh[14] = 1'b1;
            8'h4D: oh[15] = 1'b1;
            8'h15: oh[16] = 1'b1;
            8'h2D: oh[17] = 1'b1;
            8'h1B: oh[18] = 1'b1;
            8'h2C: oh[19] = 1'b1;
            8'h3C: oh[20] = 1'b1;
            8'h2A: oh[21] = 1'b1;
            8'h1D: oh[22] = 1'b1;
            8'h22: oh[23] = 1'b1;
            8'h35: oh[24] = 1'b1;
            8'h1A: oh[25] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic is_letter(input logic [7:0] code);
        return |scan_to_onehot(code);
    endfunction

endpackage

// File: rtl/ps2_letter_decoder_if.sv
// PS/2 line inputs and decoded outputs of the letter decoder.
// master = keyboard/host side, slave = decoder side.
interface ps2_letter_decoder_if;

    logic                                      PS2_CLK;
    logic                                      PS2_DAT;
    logic [7:0]                                scan_code;
    logic                                      byte_valid;
    logic [ps2_letter_decoder_pkg::LETTER_W-1:0] letter;
    logic                                      letter_valid;
    logic                                      frame_error;

    modport master (
        output PS2_CLK, PS2_DAT,
        input  scan_code, byte_valid, letter, letter_valid, frame_error
    );

    modport slave (
        input  PS2_CLK, PS2_DAT,
        output scan_code, byte_valid, letter, letter_valid, frame_error
    );

endinterface

// File: rtl/ps2_letter_decoder_rx_frame.sv
// PS/2 frame receiver: line synchronisers, start/data/parity/stop FSM and
// the inter-edge timeout that abandons a stalled frame.
module ps2_letter_decoder_rx_frame
    import ps2_letter_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_scan_code,
    output logic       o_byte_valid,
    output logic       o_frame_error
);

    localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    frame_state_t           r_state;
    frame_state_t           w_state_nxt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_err;
    logic [TMR_W-1:0]       r_timer;
    logic [7:0]             r_scan_code;
    logic                   r_byte_valid;
    logic                   r_frame_error;
    logic                   w_sclk;
    logic                   w_sdat;
    logic                   w_fall;
    logic                   w_tmo;
    logic                   w_good;
    logic                   w_bad;

    // Idle PS/2 lines are high, so the synchronisers reset high to avoid a false fall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk = r_clk_sync[SYNC_STAGES-1];
    assign w_sdat = r_dat_sync[SYNC_STAGES-1];
    assign w_fall = r_clk_prev & ~w_sclk;
    assign w_tmo  = (r_state != ST_IDLE) && (r_timer == TMR_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A fall outranks a timeout hit in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_sdat) w_state_nxt = ST_DATA;
                    else         w_bad       = 1'b1;
                end
                ST_DATA: begin
                    if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                end
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_sdat && !r_par_err) w_good = 1'b1;
                    else                      w_bad  = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_tmo) begin
            w_state_nxt = ST_IDLE;
            w_bad       = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fall && r_state == ST_DATA) r_shift <= {w_sdat, r_shift[7:1]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt     <= 3'd0;
            r_par_err     <= 1'b0;
            r_timer       <= '0;
            r_scan_code   <= 8'd0;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= 3'd0;
                        r_par_err <= 1'b0;
                    end
                    ST_DATA:   r_bit_cnt <= r_bit_cnt + 3'd1;
                    // Odd parity: data plus parity bit must hold an odd number of ones.
                    ST_PARITY: r_par_err <= ~(^{r_shift, w_sdat});
                    default:   r_bit_cnt <= r_bit_cnt;
                endcase
            end
            if (w_fall || w_tmo || r_state == ST_IDLE) r_timer <= '0;
            else                                       r_timer <= r_timer + TMR_W'(1);
            if (w_good) r_scan_code <= r_shift;
            r_byte_valid  <= w_good;
            r_frame_error <= w_bad;
        end
    end

    assign o_scan_code   = r_scan_code;
    assign o_byte_valid  = r_byte_valid;
    assign o_frame_error = r_frame_error;

endmodule

// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard receiver with break/extended prefix handling and typematic
// repeat suppression, producing the one-hot A-Z letter bus.
module ps2_letter_decoder
    import ps2_letter_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    ps2_letter_decoder_if.slave   io_bus
);

    logic [7:0]          w_scan_code;
    logic                w_byte_valid;
    logic                w_frame_error;
    logic                r_brk;
    logic                r_ext;
    logic [7:0]          r_held;
    logic [LETTER_W-1:0] r_letter;
    logic                r_letter_valid;

    ps2_letter_decoder_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .i_clk         (CLOCK_50),
        .i_rst_n       (reset),
        .i_ps2_clk     (io_bus.PS2_CLK),
        .i_ps2_dat     (io_bus.PS2_DAT),
        .o_scan_code   (w_scan_code),
        .o_byte_valid  (w_byte_valid),
        .o_frame_error (w_frame_error)
    );

    // A prefixed byte only clears the prefixes; a break of the held key re-arms it.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_brk          <= 1'b0;
            r_ext          <= 1'b0;
            r_held         <= 8'd0;
            r_letter       <= '0;
            r_letter_valid <= 1'b0;
        end else begin
            r_letter_valid <= 1'b0;
            if (w_byte_valid) begin
                if (w_scan_code == PS2_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_scan_code == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_brk || r_ext) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (r_brk && w_scan_code == r_held) r_held <= 8'd0;
                end else if (is_letter(w_scan_code)) begin
                    if (!(SUPPRESS_REPEAT != 0 && w_scan_code == r_held)) begin
                        r_letter       <= scan_to_onehot(w_scan_code);
                        r_letter_valid <= 1'b1;
                        r_held         <= w_scan_code;
                    end
                end
            end
        end
    end

    assign io_bus.scan_code    = w_scan_code;
    assign io_bus.byte_valid   = w_byte_valid;
    assign io_bus.frame_error  = w_frame_error;
    assign io_bus.letter       = r_letter;
    assign io_bus.letter_valid = r_letter_valid;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Bench for ps2_letter_decoder: directed PS/2 frames followed by random
// byte streams, checked against a keyboard-level reference model.
module tb_ps2_letter_decoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ps2_letter_decoder_if bus ();

    ps2_letter_decoder #(
        .TIMEOUT_CYCLES  (100),
        .SYNC_STAGES     (2),
        .SUPPRESS_REPEAT (1)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .io_bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse monitor: counts pulses and records width/exclusion/latency violations.
    int   n_bv, n_fe, n_lv;
    int   width_viol, excl_viol, lat_viol;
    logic p_bv, p_fe, p_lv;
    initial begin
        n_bv = 0; n_fe = 0; n_lv = 0;
        width_viol = 0; excl_viol = 0; lat_viol = 0;
        p_bv = 1'b0; p_fe = 1'b0; p_lv = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) n_bv = n_bv + 1;
        if (bus.frame_error === 1'b1) n_fe = n_fe + 1;
        if (bus.letter_valid === 1'b1) n_lv = n_lv + 1;
        if ((bus.byte_valid && p_bv) || (bus.frame_error && p_fe) || (bus.letter_valid && p_lv))
            width_viol = width_viol + 1;
        if (bus.byte_valid && bus.frame_error) excl_viol = excl_viol + 1;
        if (bus.letter_valid && !p_bv) lat_viol = lat_viol + 1;
        p_bv = bus.byte_valid;
        p_fe = bus.frame_error;
        p_lv = bus.letter_valid;
    end

    // Reference model state: keyboard-level view of what the decoder should hold.
    byte unsigned letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                        8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                        8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned other_codes [6] = '{8'h16, 8'h1E, 8'h26, 8'h29, 8'h5A, 8'h66};
    bit          m_brk, m_ext;
    logic [7:0]  m_held;
    logic [7:0]  m_scan;
    logic [25:0] m_letter;
    int          s_bv, s_fe, s_lv;

    task automatic model_reset();
        m_brk = 1'b0; m_ext = 1'b0; m_held = 8'h00; m_scan = 8'h00; m_letter = '0;
    endtask

    function automatic int letter_index(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (letter_codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b, output int lv);
        int idx;
        lv  = 0;
        idx = letter_index(b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_brk || m_ext) begin
            if (m_brk && b == m_held) m_held = 8'h00;
            m_brk = 1'b0; m_ext = 1'b0;
        end else if (idx >= 0 && b != m_held) begin
            m_letter = 26'd1 << idx;
            m_held   = b;
            lv       = 1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        s_bv = n_bv; s_fe = n_fe; s_lv = n_lv;
    endtask

    task automatic check_counts(input string tag, input int e_bv, input int e_fe, input int e_lv);
        check_val({tag, " byte_valid count"}, 32'(n_bv - s_bv), 32'(e_bv));
        check_val({tag, " frame_error count"}, 32'(n_fe - s_fe), 32'(e_fe));
        check_val({tag, " letter_valid count"}, 32'(n_lv - s_lv), 32'(e_lv));
        check_val({tag, " scan_code"}, 32'(bus.scan_code), 32'(m_scan));
        check_val({tag, " letter"}, 32'(bus.letter), 32'(m_letter));
    endtask

    task automatic ps2_bit(input logic v);
        bus.PS2_DAT = v;
        wait_cyc(5);
        bus.PS2_CLK = 1'b0;
        wait_cyc(10);
        bus.PS2_CLK = 1'b1;
        wait_cyc(5);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        int   lv;
        p = ~^b;
        if (!par_ok) p = ~p;
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(stop_ok);
        bus.PS2_DAT = 1'b1;
        wait_cyc(10);
        if (par_ok && stop_ok) begin
            m_scan = b;
            model_byte(b, lv);
            check_counts(tag, 1, 0, lv);
        end else begin
            check_counts(tag, 0, 1, 0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, " scan_code"}, 32'(bus.scan_code), 32'h0);
        check_val({tag, " byte_valid"}, 32'(bus.byte_valid), 32'h0);
        check_val({tag, " letter"}, 32'(bus.letter), 32'h0);
        check_val({tag, " letter_valid"}, 32'(bus.letter_valid), 32'h0);
        check_val({tag, " frame_error"}, 32'(bus.frame_error), 32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] last_b;
        int         sel;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n       = 1'b0;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        wait_cyc(5);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        send_frame("A make", 8'h1C, 1'b1, 1'b1);
        send_frame("Z make", 8'h1A, 1'b1, 1'b1);
        send_frame("break prefix", 8'hF0, 1'b1, 1'b1);
        send_frame("Z break", 8'h1A, 1'b1, 1'b1);
        send_frame("Z make after break", 8'h1A, 1'b1, 1'b1);
        send_frame("A repeat 1", 8'h1C, 1'b1, 1'b1);
        send_frame("A repeat 2", 8'h1C, 1'b1, 1'b1);
        send_frame("A repeat 3", 8'h1C, 1'b1, 1'b1);
        send_frame("bad parity", 8'h1C, 1'b0, 1'b1);
        send_frame("bad stop", 8'h32, 1'b1, 1'b0);

        snap();
        ps2_bit(1'b1);
        wait_cyc(10);
        check_counts("bad start", 0, 1, 0);

        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        bus.PS2_DAT = 1'b1;
        wait_cyc(300);
        check_counts("timeout", 0, 1, 0);
        send_frame("B after timeout", 8'h32, 1'b1, 1'b1);

        send_frame("ext prefix", 8'hE0, 1'b1, 1'b1);
        send_frame("ext A", 8'h1C, 1'b1, 1'b1);
        send_frame("key 1", 8'h16, 1'b1, 1'b1);

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        #5;
        check_outputs_zero("reset mid-frame");
        model_reset();
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);
        send_frame("A after reset", 8'h1C, 1'b1, 1'b1);

        last_b = 8'h1C;
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: rb = letter_codes[$urandom_range(0, 3)];
                3:       rb = letter_codes[$urandom_range(0, 25)];
                4, 5:    rb = 8'hF0;
                6:       rb = 8'hE0;
                7:       rb = other_codes[$urandom_range(0, 5)];
                default: rb = last_b;
            endcase
            send_frame("random", rb, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
            last_b = rb;
        end

        check_val("pulse width", 32'(width_viol), 32'h0);
        check_val("byte_valid/frame_error exclusive", 32'(excl_viol), 32'h0);
        check_val("letter_valid latency", 32'(lat_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
